// File: rtl/bus_pkg.sv
// Shared constants for the bus arbiter: chip-enable indices, FSM state type
// and the acp open-bus read mask.
package bus_pkg;

    localparam int NUM_CE    = 6;
    localparam int CE_GPPRAM = 0;
    localparam int CE_PPU    = 1;
    localparam int CE_ACP    = 2;
    localparam int CE_IO     = 3;
    localparam int CE_SDRAM  = 4;
    localparam int CE_CART   = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Indexed by addr[4:0] inside $4000-$401F; a 1 means a read returns the
    // open-bus latch. Only $4015-$4017 are backed by the acp slave.
    localparam logic [31:0] ACP_OB_MASK = 32'hFF1F_FFFF;

endpackage

// File: rtl/bus_region_decode.sv
// Combinational address decode: one-hot chip enable, wait-state count and
// open-bus select for the acp window.
module bus_region_decode
    import bus_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int SDRAM_WAIT = 2,
    parameter int CART_WAIT  = 1
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [NUM_CE-1:0] o_ce,
    output logic [3:0]        o_wait,
    output logic              o_ob_sel
);

    always_comb begin
        o_ce     = '0;
        o_wait   = '0;
        o_ob_sel = 1'b0;
        unique case (i_addr[ADDR_W-1:ADDR_W-3])
            3'd0: o_ce[CE_GPPRAM] = 1'b1;
            3'd1: o_ce[CE_PPU]    = 1'b1;
            3'd2: begin
                // Only the first 32 bytes of $4000-$5FFF belong to the acp.
                if (i_addr[ADDR_W-4:5] == '0) begin
                    o_ce[CE_ACP] = 1'b1;
                    o_ob_sel     = ACP_OB_MASK[i_addr[4:0]];
                end else begin
                    o_ce[CE_IO] = 1'b1;
                end
            end
            3'd3: begin
                o_ce[CE_SDRAM] = 1'b1;
                o_wait         = 4'(SDRAM_WAIT);
            end
            default: begin
                o_ce[CE_CART] = 1'b1;
                o_wait        = 4'(CART_WAIT);
            end
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (CPU, DMA) bus arbiter with region decode, wait states and an
// open-bus latch. DMA wins when both request in the same IDLE cycle.
//
// state     | meaning
// ST_IDLE   | sample requests, latch winner, load wait counter
// ST_ACCESS | chip enable asserted, count down wait states
// ST_DONE   | one-cycle ready pulse to the owning master
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int              ADDR_W       = 16,
    parameter int              DATA_W       = 8,
    parameter int              SDRAM_WAIT   = 2,
    parameter int              CART_WAIT    = 1,
    parameter logic [DATA_W-1:0] OPEN_BUS_RST = 8'hFF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cpu_req,
    input  logic                     i_cpu_rnw,
    input  logic [ADDR_W-1:0]        i_cpu_addr,
    input  logic [DATA_W-1:0]        i_cpu_wdata,
    output logic                     o_cpu_ready,
    output logic [DATA_W-1:0]        o_cpu_rdata,
    input  logic                     i_dma_req,
    input  logic                     i_dma_rnw,
    input  logic [ADDR_W-1:0]        i_dma_addr,
    input  logic [DATA_W-1:0]        i_dma_wdata,
    output logic                     o_dma_ready,
    output logic [DATA_W-1:0]        o_dma_rdata,
    output logic                     o_dma_grant,
    output logic [NUM_CE-1:0]        o_ce,
    output logic [ADDR_W-1:0]        o_addr,
    output logic                     o_rnw,
    output logic [DATA_W-1:0]        o_wdata,
    input  logic [NUM_CE*DATA_W-1:0] i_slave_rdata
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic                r_owner_dma;
    logic [DATA_W-1:0]   r_open_bus;

    logic                w_any_req;
    logic [ADDR_W-1:0]   w_dec_addr;
    logic [NUM_CE-1:0]   w_ce;
    logic [3:0]          w_wait;
    logic                w_ob_sel;
    logic [DATA_W-1:0]   w_slice;
    logic [DATA_W-1:0]   w_cap;

    assign w_any_req = i_cpu_req | i_dma_req;

    // The single decoder sees the incoming winner in IDLE (to load the
    // counter) and the latched address for the rest of the transaction.
    assign w_dec_addr = (r_state == ST_IDLE) ? (i_dma_req ? i_dma_addr : i_cpu_addr)
                                             : o_addr;

    bus_region_decode #(
        .ADDR_W     (ADDR_W),
        .SDRAM_WAIT (SDRAM_WAIT),
        .CART_WAIT  (CART_WAIT)
    ) u_decode (
        .i_addr   (w_dec_addr),
        .o_ce     (w_ce),
        .o_wait   (w_wait),
        .o_ob_sel (w_ob_sel)
    );

    always_comb begin
        w_slice = '0;
        for (int k = 0; k < NUM_CE; k++) begin
            if (w_ce[k]) w_slice |= i_slave_rdata[k*DATA_W +: DATA_W];
        end
    end

    assign w_cap = w_ob_sel ? r_open_bus : w_slice;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_any_req) w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (r_cnt == 4'd0) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_owner_dma <= 1'b0;
            r_open_bus  <= OPEN_BUS_RST;
            o_addr      <= '0;
            o_rnw       <= 1'b1;
            o_wdata     <= '0;
            o_cpu_rdata <= '0;
            o_dma_rdata <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner_dma <= i_dma_req;
                        o_addr      <= i_dma_req ? i_dma_addr  : i_cpu_addr;
                        o_rnw       <= i_dma_req ? i_dma_rnw   : i_cpu_rnw;
                        o_wdata     <= i_dma_req ? i_dma_wdata : i_cpu_wdata;
                        r_cnt       <= w_wait;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (o_rnw) begin
                        r_open_bus <= w_cap;
                        if (r_owner_dma) o_dma_rdata <= w_cap;
                        else             o_cpu_rdata <= w_cap;
                    end else begin
                        r_open_bus <= o_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ce        = (r_state == ST_ACCESS) ? w_ce : '0;
    assign o_cpu_ready = (r_state == ST_DONE) && !r_owner_dma;
    assign o_dma_ready = (r_state == ST_DONE) &&  r_owner_dma;
    assign o_dma_grant = (r_state != ST_IDLE) &&  r_owner_dma;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized self-checking bench for bus_arbiter against a transaction-level
// model of the region map, wait states, arbitration and open-bus latch.
module tb_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int SW = 2;
    localparam int CW = 1;

    typedef struct {
        bit         en;
        bit         rnw;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_rnw, dma_req, dma_rnw;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic        o_cpu_ready, o_dma_ready, o_dma_grant, o_rnw;
    logic [7:0]  o_cpu_rdata, o_dma_rdata, o_wdata;
    logic [5:0]  o_ce;
    logic [15:0] o_addr;
    logic [7:0]  slave [6];
    logic [47:0] slave_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_ob, m_cpu_rd, m_dma_rd;

    always #5 clk = ~clk;

    always_comb begin
        slave_rdata = '0;
        for (int k = 0; k < 6; k++) slave_rdata[k*8 +: 8] = slave[k];
    end

    bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .SDRAM_WAIT(SW), .CART_WAIT(CW), .OPEN_BUS_RST(8'hFF)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_rnw(cpu_rnw), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_ready(o_cpu_ready), .o_cpu_rdata(o_cpu_rdata),
        .i_dma_req(dma_req), .i_dma_rnw(dma_rnw), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
        .o_dma_ready(o_dma_ready), .o_dma_rdata(o_dma_rdata), .o_dma_grant(o_dma_grant),
        .o_ce(o_ce), .o_addr(o_addr), .o_rnw(o_rnw), .o_wdata(o_wdata),
        .i_slave_rdata(slave_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int region_of(input logic [15:0] a);
        if (a < 16'h2000) return 0;
        if (a < 16'h4000) return 1;
        if (a < 16'h4020) return 2;
        if (a < 16'h6000) return 3;
        if (a < 16'h8000) return 4;
        return 5;
    endfunction

    function automatic int wait_of(input int r);
        if (r == 4) return SW;
        if (r == 5) return CW;
        return 0;
    endfunction

    function automatic bit ob_hit(input logic [15:0] a);
        return (a >= 16'h4000 && a <= 16'h4014) || (a >= 16'h4018 && a <= 16'h401F);
    endfunction

    function automatic txn_t mk(input bit rnw, input logic [15:0] a, input logic [7:0] wd);
        txn_t t;
        t.en = 1'b1; t.rnw = rnw; t.addr = a; t.wdata = wd;
        return t;
    endfunction

    function automatic txn_t none();
        txn_t t;
        t.en = 1'b0; t.rnw = 1'b1; t.addr = '0; t.wdata = '0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.en    = 1'b1;
        t.rnw   = 1'($urandom_range(0, 1));
        t.wdata = 8'($urandom);
        case ($urandom_range(0, 6))
            0:       t.addr = 16'($urandom_range(16'h0000, 16'h1FFF));
            1:       t.addr = 16'($urandom_range(16'h2000, 16'h3FFF));
            2:       t.addr = 16'($urandom_range(16'h4000, 16'h401F));
            3:       t.addr = 16'($urandom_range(16'h4020, 16'h5FFF));
            4:       t.addr = 16'($urandom_range(16'h6000, 16'h7FFF));
            5:       t.addr = 16'($urandom_range(16'h8000, 16'hFFFF));
            default: t.addr = 16'($urandom_range(16'h4013, 16'h4019));
        endcase
        return t;
    endfunction

    // Expected results come from serving DMA first, then the CPU.
    task automatic run_pair(input txn_t c, input txn_t d);
        int rc, rd, d_rdy, c_start, c_rdy, last;
        logic [7:0] exp_c, exp_d;
        logic [5:0] exp_ce;
        rc = region_of(c.addr);
        rd = region_of(d.addr);
        d_rdy   = d.en ? wait_of(rd) + 2 : 0;
        c_start = d.en ? d_rdy + 1 : 0;
        c_rdy   = c.en ? c_start + wait_of(rc) + 2 : 0;
        last    = (c_rdy > d_rdy) ? c_rdy : d_rdy;

        exp_d = m_dma_rd;
        if (d.en) begin
            if (d.rnw) begin
                exp_d = ob_hit(d.addr) ? m_ob : slave[rd];
                m_ob  = exp_d;
            end else begin
                m_ob = d.wdata;
            end
            m_dma_rd = exp_d;
        end
        exp_c = m_cpu_rd;
        if (c.en) begin
            if (c.rnw) begin
                exp_c = ob_hit(c.addr) ? m_ob : slave[rc];
                m_ob  = exp_c;
            end else begin
                m_ob = c.wdata;
            end
            m_cpu_rd = exp_c;
        end

        cpu_req = c.en; cpu_rnw = c.rnw; cpu_addr = c.addr; cpu_wdata = c.wdata;
        dma_req = d.en; dma_rnw = d.rnw; dma_addr = d.addr; dma_wdata = d.wdata;

        for (int n = 1; n <= last; n++) begin
            @(posedge clk); #1;
            exp_ce = '0;
            if (d.en && n < d_rdy) begin
                exp_ce = 6'(1 << rd);
                check("dma_addr", 32'(o_addr), 32'(d.addr));
                check("dma_rnw", 32'(o_rnw), 32'(d.rnw));
                if (!d.rnw) check("dma_wdata", 32'(o_wdata), 32'(d.wdata));
            end
            if (c.en && n > c_start && n < c_rdy) begin
                exp_ce = 6'(1 << rc);
                check("cpu_addr", 32'(o_addr), 32'(c.addr));
                check("cpu_rnw", 32'(o_rnw), 32'(c.rnw));
                if (!c.rnw) check("cpu_wdata", 32'(o_wdata), 32'(c.wdata));
            end
            check("ce", 32'(o_ce), 32'(exp_ce));
            check("cpu_ready", 32'(o_cpu_ready), 32'(c.en && n == c_rdy));
            check("dma_ready", 32'(o_dma_ready), 32'(d.en && n == d_rdy));
            check("grant", 32'(o_dma_grant), 32'(d.en && n <= d_rdy));
            if (d.en && n == d_rdy) begin
                check("dma_rdata", 32'(o_dma_rdata), 32'(exp_d));
                dma_req = 1'b0;
            end
            if (c.en && n == c_rdy) begin
                check("cpu_rdata", 32'(o_cpu_rdata), 32'(exp_c));
                cpu_req = 1'b0;
            end
            // Scramble the in-flight master's inputs once it has been accepted.
            if (d.en && n == 1) begin
                dma_addr = 16'($urandom); dma_wdata = 8'($urandom); dma_rnw = ~d.rnw;
            end
            if (c.en && n == c_start + 1) begin
                cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom); cpu_rnw = ~c.rnw;
            end
        end
        @(posedge clk); #1;
        check("idle_ce", 32'(o_ce), 32'(0));
        check("cpu_hold", 32'(o_cpu_rdata), 32'(m_cpu_rd));
        check("dma_hold", 32'(o_dma_rdata), 32'(m_dma_rd));
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_rnw = 1'b1; dma_addr = '0; dma_wdata = '0;
        for (int k = 0; k < 6; k++) slave[k] = 8'($urandom);
        m_ob = 8'hFF; m_cpu_rd = '0; m_dma_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ce", 32'(o_ce), 32'(0));
        check("rst_cpu_ready", 32'(o_cpu_ready), 32'(0));
        check("rst_dma_ready", 32'(o_dma_ready), 32'(0));
        check("rst_grant", 32'(o_dma_grant), 32'(0));
        check("rst_addr", 32'(o_addr), 32'(0));
        check("rst_rnw", 32'(o_rnw), 32'(1));
        check("rst_wdata", 32'(o_wdata), 32'(0));
        check("rst_cpu_rdata", 32'(o_cpu_rdata), 32'(0));
        check("rst_dma_rdata", 32'(o_dma_rdata), 32'(0));
        rst_n = 1'b1;

        slave[0] = 8'h5A;
        run_pair(mk(1'b1, 16'h0123, 8'h00), none());
        slave[5] = 8'hC3;
        run_pair(mk(1'b1, 16'h8000, 8'h00), none());
        slave[0] = 8'h21;
        run_pair(mk(1'b1, 16'h0010, 8'h00), mk(1'b0, 16'h2004, 8'h11));
        slave[2] = 8'hAA;
        run_pair(mk(1'b0, 16'h4000, 8'h3C), none());
        run_pair(mk(1'b1, 16'h4000, 8'h00), none());
        run_pair(mk(1'b1, 16'h4015, 8'h00), none());
        run_pair(mk(1'b1, 16'h4017, 8'h00), none());
        run_pair(mk(1'b1, 16'h4018, 8'h00), none());
        slave[3] = 8'h9E;
        run_pair(none(), mk(1'b1, 16'h4020, 8'h00));
        run_pair(mk(1'b1, 16'h7FFF, 8'h00), mk(1'b1, 16'h401F, 8'h00));

        // Reset in the middle of an sdram access.
        slave[4] = 8'h77;
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 16'h6000;
        @(posedge clk); #1;
        check("pre_rst_ce", 32'(o_ce), 32'(6'b010000));
        @(posedge clk); #1;
        rst_n = 1'b0; cpu_req = 1'b0;
        #1;
        check("rst_mid_ce", 32'(o_ce), 32'(0));
        check("rst_mid_ready", 32'(o_cpu_ready), 32'(0));
        check("rst_mid_rdata", 32'(o_cpu_rdata), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_ready", 32'(o_cpu_ready), 32'(0));
        m_ob = 8'hFF; m_cpu_rd = '0; m_dma_rd = '0;
        run_pair(mk(1'b1, 16'h4000, 8'h00), none());
        run_pair(mk(1'b1, 16'h6000, 8'h00), none());

        for (int i = 0; i < 60; i++) begin
            int mode;
            for (int k = 0; k < 6; k++) slave[k] = 8'($urandom);
            mode = $urandom_range(1, 3);
            run_pair(mode[0] ? rand_txn() : none(), mode[1] ? rand_txn() : none());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
